// File: rtl/regfile_write_sched.sv
// regfile_write_sched
// Write-port scheduler for a two-write-port register file.
// Each requester owns a small FIFO of {addr, data} writes. Every cycle up to
// two FIFO heads are granted round-robin and registered onto the two write
// ports. Two writes to the same register are never issued in one cycle,
// because the register file XORs the two selects and such a write would be
// lost.
//
// Ports
//   clk        clock, all state updates on the rising edge
//   rst_n      asynchronous active-low reset
//   req_valid  per-requester write offer
//   req_ready  per-requester FIFO has space (registered state only)
//   req_addr   packed dest registers, requester i at [i*ADDR_W +: ADDR_W]
//   req_data   packed write data, requester i at [i*DATA_W +: DATA_W]
//   wr_sel0/1  {write enable, addr} for write port 0/1
//   wr_data0/1 write data for port 0/1 (holds its value when the port is idle)
//   busy       any FIFO non-empty or any write port enabled
module regfile_write_sched #(
    parameter int NUM_REQ    = 4,
    parameter int FIFO_DEPTH = 2,
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [ADDR_W:0]           wr_sel0,
    output logic [DATA_W-1:0]         wr_data0,
    output logic [ADDR_W:0]           wr_sel1,
    output logic [DATA_W-1:0]         wr_data1,
    output logic                      busy
);
    localparam int PTR_W = $clog2(NUM_REQ);
    localparam int FW    = $clog2(FIFO_DEPTH);
    localparam int CW    = FW + 1;

    // FIFO storage (data path, not reset)
    logic [ADDR_W-1:0] mem_addr_q [NUM_REQ][FIFO_DEPTH];
    logic [DATA_W-1:0] mem_data_q [NUM_REQ][FIFO_DEPTH];

    // FIFO control
    logic [FW-1:0]     wptr_q [NUM_REQ];
    logic [FW-1:0]     wptr_d [NUM_REQ];
    logic [FW-1:0]     rptr_q [NUM_REQ];
    logic [FW-1:0]     rptr_d [NUM_REQ];
    logic [CW-1:0]     cnt_q  [NUM_REQ];
    logic [CW-1:0]     cnt_d  [NUM_REQ];
    logic [PTR_W-1:0]  rr_ptr_q, rr_ptr_d;

    // Registered write ports
    logic [ADDR_W:0]   wr_sel0_q, wr_sel0_d;
    logic [ADDR_W:0]   wr_sel1_q, wr_sel1_d;
    logic [DATA_W-1:0] wr_data0_q, wr_data0_d;
    logic [DATA_W-1:0] wr_data1_q, wr_data1_d;

    logic [NUM_REQ-1:0] empty, full, push, pop;
    logic [ADDR_W-1:0]  head_addr [NUM_REQ];
    logic [DATA_W-1:0]  head_data [NUM_REQ];

    logic               gnt_a_vld, gnt_b_vld;
    logic [PTR_W-1:0]   gnt_a_idx, gnt_b_idx;

    // FIFO status and accept handshake; ready never depends on this cycle's pop.
    always_comb begin : fifo_status
        empty     = '0;
        full      = '0;
        req_ready = '0;
        push      = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            empty[i]     = (cnt_q[i] == '0);
            full[i]      = (cnt_q[i] == CW'(FIFO_DEPTH));
            head_addr[i] = mem_addr_q[i][rptr_q[i]];
            head_data[i] = mem_data_q[i][rptr_q[i]];
            req_ready[i] = rst_n & ~full[i];
            push[i]      = req_valid[i] & req_ready[i];
        end
    end

    // Round-robin scan from rr_ptr_q. Grant B must target a different
    // register than grant A; heads colliding with A simply wait.
    always_comb begin : arbitrate
        logic [PTR_W-1:0] idx;
        idx       = '0;
        gnt_a_vld = 1'b0;
        gnt_a_idx = '0;
        gnt_b_vld = 1'b0;
        gnt_b_idx = '0;
        for (int j = 0; j < NUM_REQ; j++) begin
            idx = PTR_W'((int'(rr_ptr_q) + j) % NUM_REQ);
            if (!empty[idx]) begin
                if (!gnt_a_vld) begin
                    gnt_a_vld = 1'b1;
                    gnt_a_idx = idx;
                end else if (!gnt_b_vld && (head_addr[idx] != head_addr[gnt_a_idx])) begin
                    gnt_b_vld = 1'b1;
                    gnt_b_idx = idx;
                end
            end
        end
    end

    // FIFO pointer/count update; push and pop on one FIFO leave count unchanged.
    always_comb begin : fifo_next
        pop = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            pop[i]    = (gnt_a_vld && (gnt_a_idx == PTR_W'(i))) ||
                        (gnt_b_vld && (gnt_b_idx == PTR_W'(i)));
            wptr_d[i] = push[i] ? wptr_q[i] + FW'(1) : wptr_q[i];
            rptr_d[i] = pop[i]  ? rptr_q[i] + FW'(1) : rptr_q[i];
            cnt_d[i]  = cnt_q[i] + CW'(push[i]) - CW'(pop[i]);
        end
    end

    // Issue selects, hold idle data buses, and advance the RR pointer past
    // the last requester granted in scan order.
    always_comb begin : issue_next
        wr_sel0_d  = gnt_a_vld ? {1'b1, head_addr[gnt_a_idx]} : '0;
        wr_data0_d = gnt_a_vld ? head_data[gnt_a_idx] : wr_data0_q;
        wr_sel1_d  = gnt_b_vld ? {1'b1, head_addr[gnt_b_idx]} : '0;
        wr_data1_d = gnt_b_vld ? head_data[gnt_b_idx] : wr_data1_q;
        rr_ptr_d   = rr_ptr_q;
        if (gnt_b_vld) begin
            rr_ptr_d = PTR_W'((int'(gnt_b_idx) + 1) % NUM_REQ);
        end else if (gnt_a_vld) begin
            rr_ptr_d = PTR_W'((int'(gnt_a_idx) + 1) % NUM_REQ);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                wptr_q[i] <= '0;
                rptr_q[i] <= '0;
                cnt_q[i]  <= '0;
            end
            rr_ptr_q   <= '0;
            wr_sel0_q  <= '0;
            wr_sel1_q  <= '0;
            wr_data0_q <= '0;
            wr_data1_q <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                wptr_q[i] <= wptr_d[i];
                rptr_q[i] <= rptr_d[i];
                cnt_q[i]  <= cnt_d[i];
            end
            rr_ptr_q   <= rr_ptr_d;
            wr_sel0_q  <= wr_sel0_d;
            wr_sel1_q  <= wr_sel1_d;
            wr_data0_q <= wr_data0_d;
            wr_data1_q <= wr_data1_d;
        end
    end

    always_ff @(posedge clk) begin : fifo_storage
        for (int i = 0; i < NUM_REQ; i++) begin
            if (push[i]) begin
                mem_addr_q[i][wptr_q[i]] <= req_addr[i*ADDR_W +: ADDR_W];
                mem_data_q[i][wptr_q[i]] <= req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    assign wr_sel0  = wr_sel0_q;
    assign wr_sel1  = wr_sel1_q;
    assign wr_data0 = wr_data0_q;
    assign wr_data1 = wr_data1_q;
    assign busy     = (|(~empty)) | wr_sel0_q[ADDR_W] | wr_sel1_q[ADDR_W];

endmodule
